config_rd_arb: RTL and testbench

CONFIG_RD_ARB -- requirements
Module: config_rd_arb

---
 rtl/cfg_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/config_rd_arb.sv | 126 ++++++++++++
 tb/tb_config_rd_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - default widths and config-word field layout for the neuron config ROM
package cfg_pkg;

  localparam int ADDR_WIDTH    = 8;
  localparam int DATA_WIDTH    = 66;
  localparam int DSIZE         = 16;
  localparam int AER_BIT_WIDTH = 32;

  // Config word is {NurnType, RandTh, Th_Mask, RstPot, SpikeAER}, LSB first below
  localparam int SPIKE_AER_LSB = 0;
  localparam int SPIKE_AER_W   = AER_BIT_WIDTH;
  localparam int RST_POT_LSB   = SPIKE_AER_LSB + SPIKE_AER_W;
  localparam int RST_POT_W     = DSIZE;
  localparam int TH_MASK_LSB   = RST_POT_LSB + RST_POT_W;
  localparam int TH_MASK_W     = DSIZE;
  localparam int RAND_TH_BIT   = TH_MASK_LSB + TH_MASK_W;
  localparam int NURN_TYPE_BIT = RAND_TH_BIT + 1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  int w_dist;
  int w_best;

  // Grant the requester closest to the pointer going upward with wrap
  always_comb begin
    gnt    = '0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + NUM_REQ - int'(ptr));
      if (req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        gnt    = '0;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/config_rd_arb.sv
// rtl/config_rd_arb.sv - round-robin shared config-ROM read port with latency-matched response path
module config_rd_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = cfg_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cfg_pkg::DATA_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_rdEn_o,
  input  logic [DATA_WIDTH-1:0]         mem_data_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic [NUM_REQ-1:0]            rd_vld_o
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]       r_ptr;
  logic [NUM_REQ-1:0]    w_arb_gnt;
  logic [NUM_REQ-1:0]    w_gnt;
  logic                  w_gnt_vld;
  logic [ID_W-1:0]       w_gnt_id;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;

  logic                  r_mem_rden;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ID_W-1:0]       r_issue_id;

  // One entry per ROM latency cycle; entry RD_LAT-1 lines up with mem_data_i
  logic [RD_LAT-1:0]     r_pipe_vld;
  logic [ID_W-1:0]       r_pipe_id [RD_LAT];

  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [NUM_REQ-1:0]    r_rd_vld;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_rr_arbiter (
    .req (req_i),
    .ptr (r_ptr),
    .gnt (w_arb_gnt)
  );

  assign w_gnt     = rst_i ? '0 : w_arb_gnt;
  assign w_gnt_vld = |w_gnt;

  // Encode the one-hot grant into an id and select that requester's address
  always_comb begin
    w_gnt_id   = '0;
    w_gnt_addr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_gnt[j]) begin
        w_gnt_id   = ID_W'(j);
        w_gnt_addr = addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Pointer moves just past the last granted requester
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // ROM strobe/address issue; address is held between reads
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem_rden <= 1'b0;
      r_mem_addr <= '0;
      r_issue_id <= '0;
    end else begin
      r_mem_rden <= w_gnt_vld;
      r_issue_id <= w_gnt_id;
      if (w_gnt_vld) begin
        r_mem_addr <= w_gnt_addr;
      end
    end
  end

  // Requester-id shift pipe tracking each outstanding ROM read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_id[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= r_mem_rden;
      r_pipe_id[0]  <= r_issue_id;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end
    end
  end

  // Capture ROM data and pulse the owning requester's valid bit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_data <= '0;
      r_rd_vld  <= '0;
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        r_rd_vld[j] <= r_pipe_vld[RD_LAT-1] && (r_pipe_id[RD_LAT-1] == ID_W'(j));
      end
      if (r_pipe_vld[RD_LAT-1]) begin
        r_rd_data <= mem_data_i;
      end
    end
  end

  assign gnt_o      = w_gnt;
  assign mem_rdEn_o = r_mem_rden;
  assign mem_addr_o = r_mem_addr;
  assign rd_data_o  = r_rd_data;
  assign rd_vld_o   = r_rd_vld;

endmodule

// File: tb/tb_config_rd_arb.sv
// tb/tb_config_rd_arb.sv - directed bench driving RD_LAT=1 and RD_LAT=3 instances in lockstep
module tb_config_rd_arb;

  typedef struct {
    int          cyc;
    logic [3:0]  vld;
    logic [65:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] addr = '0;
  int          cyc = 0;
  int          vec_cnt = 0;
  int          miscmp_cnt = 0;

  logic [3:0]  gnt1, rvld1, gnt3, rvld3;
  logic [7:0]  maddr1, maddr3;
  logic        mren1, mren3;
  logic [65:0] mdata1, mdata3, rdata1, rdata3;
  logic [65:0] rom1_q = '0;
  logic [65:0] rom3_q [3];

  rsp_t got1[$], got3[$], exp1[$], exp3[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [65:0] rom_word(input logic [7:0] a);
    return {2'b10, 24'hC0FFEE, ~a, 16'h0000, a, a};
  endfunction

  function automatic rsp_t make_rsp(input int c, input logic [3:0] v, input logic [65:0] d);
    rsp_t r;
    r.cyc  = c;
    r.vld  = v;
    r.data = d;
    return r;
  endfunction

  // Synchronous ROM models with 1 and 3 cycles of read latency
  always @(posedge clk) begin
    rom1_q    <= rom_word(maddr1);
    rom3_q[0] <= rom_word(maddr3);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign mdata1 = rom1_q;
  assign mdata3 = rom3_q[2];

  // Response logger
  always @(negedge clk) begin
    if (rvld1 != 4'b0000) got1.push_back(make_rsp(cyc, rvld1, rdata1));
    if (rvld3 != 4'b0000) got3.push_back(make_rsp(cyc, rvld3, rdata3));
  end

  config_rd_arb #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(66), .RD_LAT(1)) dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .addr_i     (addr),
    .gnt_o      (gnt1),
    .mem_addr_o (maddr1),
    .mem_rdEn_o (mren1),
    .mem_data_i (mdata1),
    .rd_data_o  (rdata1),
    .rd_vld_o   (rvld1)
  );

  config_rd_arb #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(66), .RD_LAT(3)) dut3 (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .addr_i     (addr),
    .gnt_o      (gnt3),
    .mem_addr_o (maddr3),
    .mem_rdEn_o (mren3),
    .mem_data_i (mdata3),
    .rd_data_o  (rdata3),
    .rd_vld_o   (rvld3)
  );

  task automatic check_vec(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_gnt(input string tag, input logic [3:0] exp);
    check_vec({tag, "_gnt1"}, 96'(gnt1), 96'(exp));
    check_vec({tag, "_gnt3"}, 96'(gnt3), 96'(exp));
  endtask

  // Response latency is RD_LAT+2 cycles after the grant cycle
  task automatic expect_rsp(input int g, input logic [3:0] v, input logic [7:0] a);
    exp1.push_back(make_rsp(g + 3, v, rom_word(a)));
    exp3.push_back(make_rsp(g + 5, v, rom_word(a)));
  endtask

  task automatic compare_rsps(input string tag);
    check_vec({tag, "_n1"}, 96'(got1.size()), 96'(exp1.size()));
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
      check_vec({tag, "_cyc1"}, 96'(got1[i].cyc), 96'(exp1[i].cyc));
      check_vec({tag, "_vld1"}, 96'(got1[i].vld), 96'(exp1[i].vld));
      check_vec({tag, "_dat1"}, 96'(got1[i].data), 96'(exp1[i].data));
    end
    check_vec({tag, "_n3"}, 96'(got3.size()), 96'(exp3.size()));
    for (int i = 0; i < exp3.size() && i < got3.size(); i++) begin
      check_vec({tag, "_cyc3"}, 96'(got3[i].cyc), 96'(exp3[i].cyc));
      check_vec({tag, "_vld3"}, 96'(got3[i].vld), 96'(exp3[i].vld));
      check_vec({tag, "_dat3"}, 96'(got3[i].data), 96'(exp3[i].data));
    end
    got1.delete();
    got3.delete();
    exp1.delete();
    exp3.delete();
  endtask

  initial begin
    int g;
    rom3_q[0] = '0;
    rom3_q[1] = '0;
    rom3_q[2] = '0;

    // Reset, then idle outputs must all be zero
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_vec("idle_ctl", 96'({gnt1, mren1, maddr1, rvld1, gnt3, mren3, maddr3, rvld3}), 96'(0));
      check_vec("idle_d1", 96'(rdata1), 96'(0));
      check_vec("idle_d3", 96'(rdata3), 96'(0));
    end

    // Single request from requester 2 at 0x15
    req  = 4'b0100;
    addr = 32'h0015_0000;
    #1;
    g = cyc;
    check_gnt("t2", 4'b0100);
    expect_rsp(g, 4'b0100, 8'h15);
    step(1);
    req = 4'b0000;
    check_vec("t2_issue1", 96'({mren1, maddr1}), 96'({1'b1, 8'h15}));
    check_vec("t2_issue3", 96'({mren3, maddr3}), 96'({1'b1, 8'h15}));
    step(4);
    check_vec("t2_hold1", 96'({mren1, maddr1}), 96'({1'b0, 8'h15}));
    check_vec("t2_hold3", 96'({mren3, maddr3}), 96'({1'b0, 8'h15}));
    step(3);
    compare_rsps("t2");

    // All four requesting continuously from a fresh pointer
    rst = 1'b1;
    step(1);
    rst  = 1'b0;
    req  = 4'b1111;
    addr = 32'h2322_2120;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_gnt("t3", 4'b0001 << (k % 4));
      expect_rsp(cyc, 4'b0001 << (k % 4), 8'(32'h20 + (k % 4)));
      step(1);
    end
    req = 4'b0000;
    step(8);
    compare_rsps("t3");

    // Requester 1 back-to-back reads at 0x00, 0x01, 0x02
    req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      addr = 32'(k) << 8;
      #1;
      check_gnt("t4", 4'b0010);
      expect_rsp(cyc, 4'b0010, 8'(k));
      step(1);
    end
    req = 4'b0000;
    step(8);
    compare_rsps("t4");

    // Reset while two reads are in flight
    req = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      addr = 32'(8'h31 + k) << 16;
      #1;
      check_gnt("t5_pre", 4'b0100);
      step(1);
    end
    rst  = 1'b1;
    req  = 4'b1001;
    addr = 32'h4A00_0049;
    #1;
    check_gnt("t5_inrst", 4'b0000);
    step(1);
    rst = 1'b0;
    #1;
    check_gnt("t5_first", 4'b0001);
    expect_rsp(cyc, 4'b0001, 8'h49);
    step(1);
    req = 4'b1000;
    #1;
    check_gnt("t5_second", 4'b1000);
    expect_rsp(cyc, 4'b1000, 8'h4A);
    step(1);
    req = 4'b0000;
    step(8);
    compare_rsps("t5");

    // Requester 0 withdraws while the pointer sits at 1
    req  = 4'b0001;
    addr = 32'h0000_0040;
    #1;
    check_gnt("t6_a", 4'b0001);
    expect_rsp(cyc, 4'b0001, 8'h40);
    step(1);
    req  = 4'b0011;
    addr = 32'h0000_4150;
    #1;
    check_gnt("t6_b", 4'b0010);
    expect_rsp(cyc, 4'b0010, 8'h41);
    step(1);
    req  = 4'b0100;
    addr = 32'h0042_0000;
    #1;
    check_gnt("t6_c", 4'b0100);
    expect_rsp(cyc, 4'b0100, 8'h42);
    step(1);
    req = 4'b0000;
    #1;
    check_gnt("t6_none", 4'b0000);
    step(8);
    compare_rsps("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
